// File: rtl/fifo_pop_serializer.sv
// -----------------------------------------------------------------------------
// fifo_pop_serializer
//
// Pops DATA_WIDTH-bit words from an upstream show-ahead FIFO and emits each
// word as N = DATA_WIDTH/OUT_WIDTH beats of OUT_WIDTH bits, LSB slice first,
// over a valid/ready handshake. A word is popped only when it can be loaded
// at once: from IDLE, or on the handshake of the final beat of the current
// word, so back-to-back words stream with no bubble.
//
// State table
//   IDLE  | no word held, output invalid
//   SHIFT | word held in the shift register, beats pending
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   flush_i       synchronous abort of the word in progress
//   fifo_empty_i  upstream FIFO empty flag
//   fifo_data_i   upstream FIFO head word (valid when fifo_empty_i = 0)
//   fifo_pop_o    pop strobe to the upstream FIFO (combinational)
//   valid_o       output beat valid
//   ready_i       downstream accepts the beat
//   data_o        output beat
//   last_o        current beat is the final slice of its word
//   busy_o        a word is held
// -----------------------------------------------------------------------------
module fifo_pop_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_pop_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [OUT_WIDTH-1:0]  data_o,
  output logic                  last_o,
  output logic                  busy_o
);

  localparam int N     = DATA_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  if ((OUT_WIDTH < 1) || (DATA_WIDTH < OUT_WIDTH) ||
      ((DATA_WIDTH % OUT_WIDTH) != 0)) begin : g_bad_width
    $error("fifo_pop_serializer: DATA_WIDTH must be a positive multiple of OUT_WIDTH");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] sreg_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  at_last;
  logic                  handshake;
  logic                  pop;
  logic [DATA_WIDTH-1:0] sreg_shifted;

  // With a single slice per word the shift path is never taken; tie it off
  // so no out-of-range part-select is generated.
  if (N > 1) begin : g_shift
    assign sreg_shifted = {{OUT_WIDTH{1'b0}}, sreg_q[DATA_WIDTH-1:OUT_WIDTH]};
  end else begin : g_no_shift
    assign sreg_shifted = '0;
  end

  assign at_last   = (cnt_q == LAST_CNT);
  assign handshake = (state_q == SHIFT) && ready_i;

  // Pop only when the word is loaded on the same edge. rst_ni is folded in
  // because the FSM sits in IDLE throughout reset and would otherwise request
  // a pop from a non-empty FIFO before the block is running.
  assign pop = rst_ni && !flush_i && !fifo_empty_i &&
               ((state_q == IDLE) || (handshake && at_last));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else if (flush_i) begin
      // Flush wins over every transition; the shift register is left as is
      // because data_o is only meaningful while valid_o is high.
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            sreg_q  <= fifo_data_i;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (handshake) begin
            if (!at_last) begin
              sreg_q <= sreg_shifted;
              cnt_q  <= cnt_q + CNT_W'(1);
            end else if (pop) begin
              sreg_q <= fifo_data_i;
              cnt_q  <= '0;
            end else begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign fifo_pop_o = pop;
  assign valid_o    = (state_q == SHIFT);
  assign busy_o     = valid_o;
  assign data_o     = sreg_q[OUT_WIDTH-1:0];
  assign last_o     = valid_o && at_last;

endmodule

// File: doc/fifo_pop_serializer.md
FIFO_POP_SERIALIZER -- requirements
Module: fifo_pop_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the word popped from the upstream FIFO.
REQ-002 Parameter OUT_WIDTH, default 8: width of each output beat; DATA_WIDTH SHALL be an integer multiple of OUT_WIDTH (elaboration error otherwise); N = DATA_WIDTH/OUT_WIDTH >= 1.
REQ-003 clk_i  input  1  clock; the block SHALL use one clock and all state is rising-edge triggered.
REQ-004 rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 flush_i  input  1  synchronous abort of the word in progress.
REQ-006 fifo_empty_i  input  1  upstream FIFO empty flag.
REQ-007 fifo_data_i  input  DATA_WIDTH  upstream FIFO head word; valid whenever fifo_empty_i=0.
REQ-008 fifo_pop_o  output  1  pop strobe to the upstream FIFO.
REQ-009 valid_o  output  1  output beat valid.
REQ-010 ready_i  input  1  downstream accepts the beat.
REQ-011 data_o  output  OUT_WIDTH  output beat.
REQ-012 last_o  output  1  current beat is the final slice of its word.
REQ-013 busy_o  output  1  a word is held (state SHIFT).

Function
REQ-014 State machine SHALL have two states: IDLE (no word held), SHIFT (word held, beats pending).
REQ-015 Registers: shift register DATA_WIDTH bits, beat counter max($clog2(N),1) bits, state.
REQ-016 IDLE with fifo_empty_i=0 and flush_i=0: fifo_pop_o=1 combinationally that cycle; fifo_data_i loads into the shift register, counter loads 0, next state SHIFT.
REQ-017 fifo_pop_o SHALL never be 1 while fifo_empty_i=1, while flush_i=1, or while rst_ni=0.
REQ-018 Latency: word at FIFO head in IDLE in cycle t -> valid_o=1 in cycle t+1.
REQ-019 valid_o = (state==SHIFT); data_o = shift register bits [OUT_WIDTH-1:0]; busy_o = valid_o.
REQ-020 Beat order SHALL be LSB-first: beat k carries fifo word bits [(k+1)*OUT_WIDTH-1 : k*OUT_WIDTH].
REQ-021 last_o = valid_o and (counter == N-1); for N=1 every beat has last_o=1.
REQ-022 Once valid_o=1, data_o and last_o SHALL stay stable until valid_o&ready_i or flush_i.
REQ-023 SHIFT, handshake, counter < N-1: shift register shifts right by OUT_WIDTH, counter increments, no pop.
REQ-024 SHIFT, handshake, counter = N-1, fifo_empty_i=0, flush_i=0: fifo_pop_o=1 same cycle, next word loads, counter=0, stay SHIFT (back-to-back, no bubble).
REQ-025 SHIFT, handshake, counter = N-1, fifo_empty_i=1: next state IDLE, no pop.
REQ-026 SHIFT without handshake: all state holds; no pop.
REQ-027 Sustained throughput with ready_i=1 and non-empty FIFO SHALL be one beat per cycle, one pop every N cycles.
REQ-028 flush_i=1 in any state: next state IDLE, counter=0, no pop that cycle, valid_o=0 next cycle; a handshake in the flush cycle still counts as transferred but nothing is popped; flush overrides every other transition.
REQ-029 No word SHALL be popped that is not subsequently emitted in full unless flush_i aborts it.

Reset
REQ-030 While rst_ni=0: state IDLE, counter 0, shift register 0; valid_o=0, last_o=0, busy_o=0, data_o=0, fifo_pop_o=0.
REQ-031 Reset assertion mid-word SHALL discard the remaining beats immediately (asynchronously); first pop after deassertion occurs no earlier than the first rising edge with rst_ni=1.

Verification
REQ-032 DATA_WIDTH=32, OUT_WIDTH=8, FIFO holds 0xDDCCBBAA, ready_i=1 -> pop at t, beats 0xAA,0xBB,0xCC,0xDD at t+1..t+4, last_o only on 0xDD, then IDLE.
REQ-033 Two words 0x44332211, 0x88776655 queued, ready_i=1 -> eight consecutive beats 0x11..0x88 with no gap; second pop coincides with the 0x44 handshake.
REQ-034 ready_i=0 for 3 cycles on beat 0xBB -> valid_o=1 and data_o=0xBB held all 3 cycles; no pop; sequence resumes unchanged.
REQ-035 flush_i pulsed during beat 0xBB -> valid_o=0 next cycle, no pop in flush cycle, next queued word restarts at its beat 0.
REQ-036 rst_ni dropped during beat 0xCC -> valid_o, fifo_pop_o, busy_o read 0 before the next clock edge; after release with FIFO empty, outputs remain 0.
REQ-037 N=1 (DATA_WIDTH=OUT_WIDTH=16), random ready_i -> every beat equals the popped word, last_o=1 on every beat, fifo_pop_o never asserted with fifo_empty_i=1.
